// File: rtl/pulse_input_conditioner_if.sv
// Signal bundle between the raw-input front end and the event-counting controller.
// The glitch_cnt member exists only when GLITCH_CNT_EN is defined.
interface pulse_input_conditioner_if;
    logic       start_raw;
    logic       event_raw;
    logic       done;
    logic       S;
    logic       X;
    logic       armed;
    logic       start_lvl;
    logic       event_lvl;
`ifdef GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (
        output start_raw, event_raw, done,
        input  S, X, armed, start_lvl, event_lvl, glitch_cnt
    );
    modport slave (
        input  start_raw, event_raw, done,
        output S, X, armed, start_lvl, event_lvl, glitch_cnt
    );
`else
    modport master (
        output start_raw, event_raw, done,
        input  S, X, armed, start_lvl, event_lvl
    );
    modport slave (
        input  start_raw, event_raw, done,
        output S, X, armed, start_lvl, event_lvl
    );
`endif
endinterface

// File: rtl/pulse_input_conditioner.sv
// Synchronise + debounce the start and event inputs, emit rise pulses S/X with a done interlock.
// Optional GLITCH_CNT_EN adds a saturating count of rejected glitches on glitch_cnt.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOW       | debounced level 0, waiting for sync=1
// RISE_CHK  | sync went high, qualifying DB_CYCLES consecutive highs
// HIGH      | debounced level 1, waiting for sync=0
// FALL_CHK  | sync went low, qualifying DB_CYCLES consecutive lows
module pulse_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int DB_W        = 8
) (
    input logic                      clk,
    input logic                      reset,
    pulse_input_conditioner_if.slave pic
);

    localparam logic [1:0] ST_LOW      = 2'b00;
    localparam logic [1:0] ST_RISE_CHK = 2'b01;
    localparam logic [1:0] ST_HIGH     = 2'b10;
    localparam logic [1:0] ST_FALL_CHK = 2'b11;

    // Down-counter: loaded on entry to a check state, qualifies on reaching zero.
    localparam logic [DB_W-1:0] CNT_LOAD = DB_W'(DB_CYCLES - 2);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
`ifdef GLITCH_CNT_EN
    logic [1:0] glitch;
`endif

    // Channel 0 is start, channel 1 is event.
    assign raw = {pic.event_raw, pic.start_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] pipe;
        logic                   sync;
        logic [1:0]             state;
        logic [DB_W-1:0]        cnt;
        logic                   lvl_q;
        logic                   tc;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pipe <= '0;
            end else begin
                pipe <= {pipe[SYNC_STAGES-2:0], raw[ch]};
            end
        end

        assign sync = pipe[SYNC_STAGES-1];
        assign tc   = (cnt == '0);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= ST_LOW;
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else begin
                case (state)
                    ST_LOW: begin
                        if (sync) begin
                            state <= ST_RISE_CHK;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    ST_RISE_CHK: begin
                        if (!sync) begin
                            state <= ST_LOW;
                        end else if (tc) begin
                            state <= ST_HIGH;
                            lvl_q <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!sync) begin
                            state <= ST_FALL_CHK;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    ST_FALL_CHK: begin
                        if (sync) begin
                            state <= ST_HIGH;
                        end else if (tc) begin
                            state <= ST_LOW;
                            lvl_q <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: state <= ST_LOW;
                endcase
            end
        end

        assign rise[ch] = (state == ST_RISE_CHK) && sync && tc;
        assign lvl[ch]  = lvl_q;
`ifdef GLITCH_CNT_EN
        assign glitch[ch] = ((state == ST_RISE_CHK) && !sync) ||
                            ((state == ST_FALL_CHK) && sync);
`endif
    end

    logic s_q;
    logic x_q;
    logic armed_q;
    logic fire_s;

    assign fire_s = rise[0] & armed_q;

    // S wins over done on the same edge; an event rise is only counted mid-run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q     <= 1'b0;
            x_q     <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            s_q <= fire_s;
            x_q <= rise[1] & ~armed_q & ~fire_s;
            if (fire_s) begin
                armed_q <= 1'b0;
            end else if (pic.done) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pic.S         = s_q;
    assign pic.X         = x_q;
    assign pic.armed     = armed_q;
    assign pic.start_lvl = lvl[0];
    assign pic.event_lvl = lvl[1];

`ifdef GLITCH_CNT_EN
    logic [7:0] gcnt;
    logic [8:0] gsum;

    assign gsum = {1'b0, gcnt} + 9'(glitch[0]) + 9'(glitch[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt <= '0;
        end else begin
            gcnt <= gsum[8] ? 8'hFF : gsum[7:0];
        end
    end

    assign pic.glitch_cnt = gcnt;
`endif

endmodule
